ir_cmd_ctrl: RTL
================

Name: ir_cmd_ctrl

Overview:
Controller and scheduler for the NEC infrared frame decoder. It enables the decoder and filters each decoded 32-bit frame: checksum check and duplicate suppression. Accepted frames are queued in a small FIFO. The block presents the FIFO, status, control and statistics to the Nios processor through an Avalon-MM slave with an interrupt. It sits between the IR decoder (frame_valid/frame_data) and the Avalon fabric.

Parameters:
FIFO_DEPTH, 8, number of queued frames (power of 2, 2..16)
HOLDOFF_CYCLES, 15000000, duplicate-suppression window in csi_clk cycles (150 ms at 100 MHz)

Ports:
csi_clk  in  1  system clock, 100 MHz
csi_reset_n  in  1  asynchronous active-low reset
avs_chipselect  in  1  slave select
avs_address  in  4  word address; only 0..3 decoded, others read 0 and ignore writes
avs_read  in  1  read strobe
avs_readdata  out  32  read data, registered
avs_write  in  1  write strobe
avs_writedata  in  32  write data
avs_irq  out  1  level interrupt
frame_valid  in  1  one-cycle pulse: a new decoded frame is on frame_data
frame_data  in  32  decoded NEC frame
dec_enable  out  1  enable to decoder = CTRL[0]

Behaviour:
- One clock, csi_clk. Reset is asynchronous and active-low on csi_reset_n.
- Reset values: all registers 0, FIFO empty, avs_readdata=0, avs_irq=0, dec_enable=0, holdoff timer expired.
- Register map:
  - 0 STATUS (RO). [0] not_empty, [1] full, [2] overflow (sticky), [12:8] level, rest 0.
  - 0 STATUS write: bit2=1 clears overflow; bit3=1 flushes the FIFO (level to 0, pointers to 0).
  - 1 DATA (RO). A read returns the FIFO head and pops it. A read when empty returns 0 and changes nothing.
  - 2 CTRL (RW). [0] enable, [1] irq_en, [2] chk_en, [3] dedup_en. Readback shows [3:0]; upper bits read 0.
  - 3 DROPS (RO). [15:0] saturating count of dropped frames. Any write to address 3 clears it.
- Read latency: exactly 1. avs_readdata is updated on the clock edge after chipselect&read; a pop takes effect on that same edge. avs_readdata holds its value when there is no read.
- Frame acceptance is evaluated in the frame_valid cycle. Checks run in priority order:
  1. enable=0: frame ignored, not counted.
  2. chk_en=1 and frame_data[31:24] != ~frame_data[23:16]: drop, DROPS+1.
  3. dedup_en=1, frame_data == last_code and holdoff timer running: drop, DROPS+1. The timer restarts; holding a key stays suppressed.
  4. FIFO full (and no simultaneous pop): drop, DROPS+1, overflow set.
  5. Otherwise: push, set last_code=frame_data, restart holdoff timer to HOLDOFF_CYCLES.
- A push is visible in STATUS and DATA on the cycle after frame_valid.
- Holdoff timer: down-counter, ceil(log2(HOLDOFF_CYCLES+1)) bits. Decrements to 0 and stops; running means nonzero. last_code persists until reset.
- Simultaneous push and pop: both happen and level is unchanged. When full, a simultaneous pop frees a slot, so the push is accepted. When empty, push plus read: the read returns 0 and the frame is queued.
- Flush and push in the same cycle: flush wins, the frame is discarded and not counted.
- DROPS saturates at 0xFFFF. A clear and an increment in the same cycle give 0.
- avs_irq is registered: irq_en & not_empty, updated one cycle after the state change. Clearing irq_en deasserts it on the next cycle.
- Clearing enable mid-frame does not alter FIFO contents. Reset mid-operation empties everything immediately.
- Pointer arithmetic: log2(FIFO_DEPTH)-bit pointers wrap modulo FIFO_DEPTH. Level is log2(FIFO_DEPTH)+1 bits, 0..FIFO_DEPTH.

Test Plan:
- Reset, then write CTRL=0x3, push frame 0x00FF12ED -> dec_enable=1; next cycle STATUS=0x00000101; avs_irq=1 one cycle later; DATA read returns 0x00FF12ED; STATUS then 0; avs_irq drops.
- CTRL=0x5, push 0x00FE12ED -> dropped, DROPS=1, FIFO empty; push 0x00FF12ED -> accepted.
- CTRL=0x9, push 0xA55A1234 twice 1000 cycles apart -> one queued, DROPS=1; push again after HOLDOFF_CYCLES idle -> second queued.
- FIFO_DEPTH=8, CTRL=0x1, push 9 distinct frames -> level 8, full=1, overflow=1, DROPS=1; 9th frame with a same-cycle DATA read -> accepted, level stays 8.
- Write STATUS=0xC -> level 0, overflow 0; write address 3 -> DROPS=0; DATA read on empty returns 0.
- Assert csi_reset_n low mid-stream with 3 frames queued -> all outputs 0 immediately; after release, STATUS=0 and CTRL=0.

Source files
------------

// File: rtl/ir_cmd_ctrl.sv
// ir_cmd_ctrl: NEC IR frame filter (checksum, duplicate holdoff) with FIFO and Avalon-MM slave
module ir_cmd_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int HOLDOFF_CYCLES = 15000000
) (
  input  logic        csi_clk,
  input  logic        csi_reset_n,
  input  logic        avs_chipselect,
  input  logic [3:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_irq,
  input  logic        frame_valid,
  input  logic [31:0] frame_data,
  output logic        dec_enable
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(HOLDOFF_CYCLES + 1);
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level;
  logic          ovf;
  logic [3:0]    ctrl;
  logic [15:0]   drops;
  logic [31:0]   last_code;
  logic [TW-1:0] timer;
  logic          not_empty, full, wr_en, rd_en, flush, fv, chk_bad, dup, pop, push, drop, drop_full;
  logic [31:0]   status, rdata;
  logic          unused_wd;
  assign unused_wd  = ^avs_writedata[31:4];
  assign dec_enable = ctrl[0];
  always_comb begin
    not_empty = level != '0;
    full      = level == (AW+1)'(FIFO_DEPTH);
    wr_en     = avs_chipselect & avs_write;
    rd_en     = avs_chipselect & avs_read;
    flush     = wr_en & (avs_address == 4'd0) & avs_writedata[3];
    pop       = rd_en & (avs_address == 4'd1) & not_empty;
    fv        = frame_valid & ctrl[0] & ~flush;
    chk_bad   = ctrl[2] & (frame_data[31:24] != ~frame_data[23:16]);
    dup       = ctrl[3] & (frame_data == last_code) & (timer != '0);
    push      = fv & ~chk_bad & ~dup & (~full | pop);
    drop_full = fv & ~chk_bad & ~dup & full & ~pop;
    drop      = fv & ~push;
    status    = {19'b0, 5'(level), 5'b0, ovf, full, not_empty};
    rdata     = avs_address == 4'd0 ? status :
                avs_address == 4'd1 ? (not_empty ? mem[rptr] : 32'd0) :
                avs_address == 4'd2 ? {28'b0, ctrl} :
                avs_address == 4'd3 ? {16'b0, drops} : 32'd0;
  end
  always_ff @(posedge csi_clk)
    if (push) mem[wptr] <= frame_data;
  always_ff @(posedge csi_clk or negedge csi_reset_n) begin
    if (!csi_reset_n) begin
      avs_readdata <= '0;
      avs_irq      <= 1'b0;
      ctrl         <= '0;
      wptr         <= '0;
      rptr         <= '0;
      level        <= '0;
      ovf          <= 1'b0;
      drops        <= '0;
      last_code    <= '0;
      timer        <= '0;
    end else begin
      if (rd_en) avs_readdata <= rdata;
      if (wr_en && avs_address == 4'd2) ctrl <= avs_writedata[3:0];
      avs_irq <= ctrl[1] & not_empty;
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        level <= '0;
      end else begin
        if (push) wptr <= wptr + 1'b1;
        if (pop) rptr <= rptr + 1'b1;
        level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (drop_full) ovf <= 1'b1;
      else if (wr_en && avs_address == 4'd0 && avs_writedata[2]) ovf <= 1'b0;
      if (wr_en && avs_address == 4'd3) drops <= '0;
      else if (drop && drops != 16'hFFFF) drops <= drops + 16'd1;
      if (push) last_code <= frame_data;
      // a suppressed repeat also re-arms the window so a held key stays quiet
      if (push || (fv && !chk_bad && dup)) timer <= TW'(HOLDOFF_CYCLES);
      else if (timer != '0) timer <= timer - TW'(1);
    end
  end
endmodule
